// File: rtl/warp_init_ctrl.sv
// warp_init_ctrl: block launch controller for the per-warp state array.
// Splits a launched block into warps, allocates the lowest free warp slot
// for each warp, writes its thread IDs lane by lane, then issues a one-cycle
// initialize strobe carrying mask, block ID, base address and regs/thread.
module warp_init_ctrl #(
    parameter int NUM_WARPS     = 16,
    parameter int WARPID_DEPTH  = $clog2(NUM_WARPS),
    parameter int NUM_BLOCKS    = 8,
    parameter int BLOCKID_DEPTH = $clog2(NUM_BLOCKS),
    parameter int R_ADDR_WIDTH  = 10,
    parameter int WARP_WIDTH    = 32,
    parameter int WARP_DEPTH    = $clog2(WARP_WIDTH),
    parameter int BLOCK_DIM     = 32,
    parameter int MAX_THREADS   = NUM_WARPS * WARP_WIDTH,
    parameter int TCNT_WIDTH    = $clog2(MAX_THREADS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     launch_valid,
    output logic                     launch_ready,
    input  logic [BLOCKID_DEPTH-1:0] launch_bid,
    input  logic [TCNT_WIDTH-1:0]    launch_threads,
    input  logic [R_ADDR_WIDTH-1:0]  launch_base_addr,
    input  logic [R_ADDR_WIDTH-1:0]  launch_reg_per_thread,
    input  logic [NUM_WARPS-1:0]     warp_valid,
    output logic [NUM_WARPS-1:0]     wi_o,
    output logic [WARPID_DEPTH-1:0]  wid_init_o,
    output logic [BLOCKID_DEPTH-1:0] bid_o,
    output logic [R_ADDR_WIDTH-1:0]  base_addr_o,
    output logic [R_ADDR_WIDTH-1:0]  reg_per_thread_o,
    output logic [WARP_WIDTH-1:0]    wmask_o,
    output logic [NUM_WARPS-1:0]     tid_we_o,
    output logic [WARP_DEPTH-1:0]    tid_wa_o,
    output logic [BLOCK_DIM-1:0]     tid_d_o,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_TID,
        S_INIT,
        S_DONE
    } state_t;

    state_t                     state;
    logic [BLOCKID_DEPTH-1:0]   bid_q;
    logic [R_ADDR_WIDTH-1:0]    rpt_q;
    // base address of the current warp, advanced by one warp stride per warp
    logic [R_ADDR_WIDTH-1:0]    base_acc;
    // first thread ID of the current warp (k * WARP_WIDTH)
    logic [BLOCK_DIM-1:0]       tid_base;
    logic [TCNT_WIDTH-1:0]      remaining;
    logic [NUM_WARPS-1:0]       used;
    logic [NUM_WARPS-1:0]       slot_oh;
    logic [WARPID_DEPTH-1:0]    slot;

    logic [NUM_WARPS-1:0]       free;
    logic [NUM_WARPS-1:0]       free_oh;
    logic [WARPID_DEPTH-1:0]    free_idx;
    logic [R_ADDR_WIDTH-1:0]    stride;
    logic [TCNT_WIDTH-1:0]      rem_next;
    logic [WARP_DEPTH-1:0]      lane_inc;

    localparam logic [TCNT_WIDTH-1:0] WARP_CNT = TCNT_WIDTH'(WARP_WIDTH);
    localparam logic [TCNT_WIDTH-1:0] MAX_CNT  = TCNT_WIDTH'(MAX_THREADS);
    localparam logic [WARP_DEPTH-1:0] LAST_LANE = WARP_DEPTH'(WARP_WIDTH - 1);

    // Thread count limited to what one MP can hold.
    function automatic logic [TCNT_WIDTH-1:0] clamp_threads(input logic [TCNT_WIDTH-1:0] thr);
        if (thr > MAX_CNT)
            return MAX_CNT;
        return thr;
    endfunction

    // Active-lane mask for a warp given the threads still to be placed.
    function automatic logic [WARP_WIDTH-1:0] warp_mask(input logic [TCNT_WIDTH-1:0] rem);
        if (rem >= WARP_CNT)
            return '1;
        return (WARP_WIDTH'(1) << rem) - WARP_WIDTH'(1);
    endfunction

    // Slots that are neither occupied nor already handed out in this launch.
    assign free     = ~warp_valid & ~used;
    assign free_oh  = free & (~free + NUM_WARPS'(1));
    assign stride   = rpt_q << WARP_DEPTH;
    assign rem_next = (remaining >= WARP_CNT) ? (remaining - WARP_CNT) : '0;
    assign lane_inc = tid_wa_o + WARP_DEPTH'(1);

    // Lowest-index free slot as a binary warp ID.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (free[i])
                free_idx = WARPID_DEPTH'(i);
        end
    end

    // Launch FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            launch_ready     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            wi_o             <= '0;
            wid_init_o       <= '0;
            bid_o            <= '0;
            base_addr_o      <= '0;
            reg_per_thread_o <= '0;
            wmask_o          <= '0;
            tid_we_o         <= '0;
            tid_wa_o         <= '0;
            tid_d_o          <= '0;
            bid_q            <= '0;
            rpt_q            <= '0;
            base_acc         <= '0;
            tid_base         <= '0;
            remaining        <= '0;
            used             <= '0;
            slot_oh          <= '0;
            slot             <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    launch_ready <= 1'b1;
                    if (launch_valid && launch_ready) begin
                        launch_ready <= 1'b0;
                        busy         <= 1'b1;
                        bid_q        <= launch_bid;
                        rpt_q        <= launch_reg_per_thread;
                        base_acc     <= launch_base_addr;
                        remaining    <= clamp_threads(launch_threads);
                        tid_base     <= '0;
                        used         <= '0;
                        if (launch_threads == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_ALLOC;
                        end
                    end
                end
                S_ALLOC: begin
                    // wait here until some slot frees up
                    if (|free) begin
                        slot     <= free_idx;
                        slot_oh  <= free_oh;
                        used     <= used | free_oh;
                        tid_we_o <= free_oh;
                        tid_wa_o <= '0;
                        tid_d_o  <= tid_base;
                        state    <= S_TID;
                    end
                end
                S_TID: begin
                    if (tid_wa_o == LAST_LANE) begin
                        tid_we_o         <= '0;
                        wi_o             <= slot_oh;
                        wid_init_o       <= slot;
                        bid_o            <= bid_q;
                        reg_per_thread_o <= rpt_q;
                        base_addr_o      <= base_acc;
                        wmask_o          <= warp_mask(remaining);
                        state            <= S_INIT;
                    end else begin
                        tid_wa_o <= lane_inc;
                        tid_d_o  <= tid_base + BLOCK_DIM'(lane_inc);
                    end
                end
                S_INIT: begin
                    wi_o      <= '0;
                    remaining <= rem_next;
                    tid_base  <= tid_base + BLOCK_DIM'(WARP_WIDTH);
                    base_acc  <= base_acc + stride;
                    if (rem_next == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ALLOC;
                    end
                end
                S_DONE: begin
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    launch_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_warp_init_ctrl.sv
// tb_warp_init_ctrl: directed scoreboard bench for warp_init_ctrl.
// Stimulus pushes the expected thread-ID writes and init strobes; a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_warp_init_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        launch_valid;
    logic        launch_ready;
    logic [2:0]  launch_bid;
    logic [9:0]  launch_threads;
    logic [9:0]  launch_base_addr;
    logic [9:0]  launch_reg_per_thread;
    logic [15:0] warp_valid;
    logic [15:0] wi_o;
    logic [3:0]  wid_init_o;
    logic [2:0]  bid_o;
    logic [9:0]  base_addr_o;
    logic [9:0]  reg_per_thread_o;
    logic [31:0] wmask_o;
    logic [15:0] tid_we_o;
    logic [4:0]  tid_wa_o;
    logic [31:0] tid_d_o;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] we;
        logic [4:0]  wa;
        logic [31:0] d;
    } tid_t;

    typedef struct {
        logic [15:0] wi;
        logic [3:0]  wid;
        logic [2:0]  bid;
        logic [9:0]  base;
        logic [9:0]  rpt;
        logic [31:0] mask;
    } init_t;

    tid_t  tid_q[$];
    init_t init_q[$];
    tid_t  te;
    init_t ie;

    warp_init_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .launch_valid          (launch_valid),
        .launch_ready          (launch_ready),
        .launch_bid            (launch_bid),
        .launch_threads        (launch_threads),
        .launch_base_addr      (launch_base_addr),
        .launch_reg_per_thread (launch_reg_per_thread),
        .warp_valid            (warp_valid),
        .wi_o                  (wi_o),
        .wid_init_o            (wid_init_o),
        .bid_o                 (bid_o),
        .base_addr_o           (base_addr_o),
        .reg_per_thread_o      (reg_per_thread_o),
        .wmask_o               (wmask_o),
        .tid_we_o              (tid_we_o),
        .tid_wa_o              (tid_wa_o),
        .tid_d_o               (tid_d_o),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected writes for one warp: lanes 0..lanes-1, optionally followed by its init strobe.
    task automatic push_warp(input int slot, input int k, input logic [31:0] mask,
                             input logic [9:0] base, input logic [2:0] bid,
                             input logic [9:0] rpt, input int lanes, input bit with_init);
        tid_t  t;
        init_t i;
        for (int l = 0; l < lanes; l++) begin
            t.we = 16'(1) << slot;
            t.wa = 5'(l);
            t.d  = 32'(k * 32 + l);
            tid_q.push_back(t);
        end
        if (with_init) begin
            i.wi   = 16'(1) << slot;
            i.wid  = 4'(slot);
            i.bid  = bid;
            i.base = base;
            i.rpt  = rpt;
            i.mask = mask;
            init_q.push_back(i);
        end
    endtask

    // Waits for launch_ready, presents one request and returns just after the accept edge.
    task automatic start_launch(input logic [2:0] b, input int thr, input logic [9:0] ba,
                                input logic [9:0] r, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!launch_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("ready_timeout", 64'(launch_ready), 64'(1));
                return;
            end
        end
        launch_valid          = 1'b1;
        launch_bid            = b;
        launch_threads        = 10'(thr);
        launch_base_addr      = ba;
        launch_reg_per_thread = r;
        @(posedge clk);
        #1;
        if (!hold)
            launch_valid = 1'b0;
    endtask

    // Counts clock edges until done is seen at a negedge; -1 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (done)
                return;
            n++;
            if (n > 3000) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(launch_ready), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_wi"},    64'(wi_o), 64'(0));
        check({tag, "_tidwe"}, 64'(tid_we_o), 64'(0));
        check({tag, "_data"},  {wid_init_o, bid_o, base_addr_o, reg_per_thread_o, wmask_o},
              64'(0));
        check({tag, "_tid"},   {27'(0), tid_wa_o, tid_d_o}, 64'(0));
    endtask

    // Scoreboard monitor: compares each presented write or strobe with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (tid_we_o != 16'h0) begin
                checks++;
                if (tid_q.size() == 0) begin
                    failures++;
                    $display("FAIL tid_unexpected: got we=%h wa=%0d d=%0d, required no write",
                             tid_we_o, tid_wa_o, tid_d_o);
                end else begin
                    te = tid_q.pop_front();
                    if (tid_we_o !== te.we || tid_wa_o !== te.wa || tid_d_o !== te.d) begin
                        failures++;
                        $display("FAIL tid_write: got we=%h wa=%0d d=%0d, required we=%h wa=%0d d=%0d",
                                 tid_we_o, tid_wa_o, tid_d_o, te.we, te.wa, te.d);
                    end
                end
            end
            if (wi_o != 16'h0) begin
                checks++;
                if (init_q.size() == 0) begin
                    failures++;
                    $display("FAIL init_unexpected: got wi=%h, required no strobe", wi_o);
                end else begin
                    ie = init_q.pop_front();
                    if (wi_o !== ie.wi || wid_init_o !== ie.wid || bid_o !== ie.bid ||
                        base_addr_o !== ie.base || reg_per_thread_o !== ie.rpt ||
                        wmask_o !== ie.mask) begin
                        failures++;
                        $display("FAIL init_strobe: got wi=%h wid=%0d bid=%0d base=%h rpt=%0d mask=%h, required wi=%h wid=%0d bid=%0d base=%h rpt=%0d mask=%h",
                                 wi_o, wid_init_o, bid_o, base_addr_o, reg_per_thread_o, wmask_o,
                                 ie.wi, ie.wid, ie.bid, ie.base, ie.rpt, ie.mask);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit seen;
        rst                   = 1'b1;
        launch_valid          = 1'b0;
        launch_bid            = '0;
        launch_threads        = '0;
        launch_base_addr      = '0;
        launch_reg_per_thread = '0;
        warp_valid            = '0;

        // reset state
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(launch_ready), 64'(0));
        @(negedge clk);
        check("ready_after_reset", 64'(launch_ready), 64'(1));
        check("busy_after_reset", 64'(busy), 64'(0));

        // single partial warp: done 35 cycles after the accept cycle
        push_warp(0, 0, 32'h0000001F, 10'h040, 3'd3, 10'd2, 32, 1'b1);
        start_launch(3'd3, 5, 10'h040, 10'd2, 1'b0);
        check("t1_busy", 64'(busy), 64'(1));
        wait_done(n);
        check("t1_done_latency", 64'(n), 64'(34));
        check("t1_busy_in_done", 64'(busy), 64'(1));

        // multi-warp with slots 0 and 2 occupied
        warp_valid = 16'h0005;
        push_warp(1, 0, 32'hFFFFFFFF, 10'h000, 3'd2, 10'd1, 32, 1'b1);
        push_warp(3, 1, 32'hFFFFFFFF, 10'h020, 3'd2, 10'd1, 32, 1'b1);
        push_warp(4, 2, 32'h0000003F, 10'h040, 3'd2, 10'd1, 32, 1'b1);
        start_launch(3'd2, 70, 10'h000, 10'd1, 1'b0);
        wait_done(n);
        check("t2_done_latency", 64'(n), 64'(102));
        warp_valid = 16'h0000;

        // full MP: stall in ALLOC until slot 7 frees
        warp_valid = 16'hFFFF;
        start_launch(3'd6, 32, 10'h100, 10'd4, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wi_o != 16'h0 || tid_we_o != 16'h0 || done)
                seen = 1'b1;
        end
        check("t3_stall_busy", 64'(busy), 64'(1));
        check("t3_stall_no_strobe", 64'(seen), 64'(0));
        warp_valid = 16'hFF7F;
        push_warp(7, 0, 32'hFFFFFFFF, 10'h100, 3'd6, 10'd4, 32, 1'b1);
        wait_done(n);
        check("t3_done_after_free", 64'(n), 64'(33));
        warp_valid = 16'h0000;

        // zero-thread launch
        start_launch(3'd1, 0, 10'h055, 10'd7, 1'b0);
        wait_done(n);
        check("t4_zero_done", 64'(n), 64'(0));
        @(negedge clk);
        check("t4_zero_ready", 64'(launch_ready), 64'(1));

        // oversized launch clamps to 16 full warps
        for (int k = 0; k < 16; k++)
            push_warp(k, k, 32'hFFFFFFFF, 10'(k * 32), 3'd7, 10'd1, 32, 1'b1);
        start_launch(3'd7, 600, 10'h000, 10'd1, 1'b0);
        wait_done(n);
        check("t5_clamp_latency", 64'(n), 64'(544));

        // base address wraps modulo 1024: 0x3F0 + 31*32 = 0x3D0
        push_warp(0, 0, 32'hFFFFFFFF, 10'h3F0, 3'd5, 10'd31, 32, 1'b1);
        push_warp(1, 1, 32'h000000FF, 10'h3D0, 3'd5, 10'd31, 32, 1'b1);
        start_launch(3'd5, 40, 10'h3F0, 10'd31, 1'b0);
        wait_done(n);
        check("t6_wrap_latency", 64'(n), 64'(68));

        // launch_valid held high, inputs changed mid-launch
        push_warp(0, 0, 32'h000003FF, 10'h100, 3'd1, 10'd3, 32, 1'b1);
        start_launch(3'd1, 10, 10'h100, 10'd3, 1'b1);
        launch_bid            = 3'd2;
        launch_threads        = 10'd33;
        launch_base_addr      = 10'h200;
        launch_reg_per_thread = 10'd1;
        push_warp(0, 0, 32'hFFFFFFFF, 10'h200, 3'd2, 10'd1, 32, 1'b1);
        push_warp(1, 1, 32'h00000001, 10'h220, 3'd2, 10'd1, 32, 1'b1);
        wait_done(n);
        check("t7_first_latency", 64'(n), 64'(34));
        check("t7_ready_in_done", 64'(launch_ready), 64'(0));
        @(negedge clk);
        check("t7_ready_idle", 64'(launch_ready), 64'(1));
        @(posedge clk);
        #1;
        launch_valid = 1'b0;
        wait_done(n);
        check("t7_second_latency", 64'(n), 64'(68));

        // asynchronous reset during lane 10
        push_warp(0, 0, 32'hFFFFFFFF, 10'h080, 3'd4, 10'd2, 11, 1'b0);
        start_launch(3'd4, 32, 10'h080, 10'd2, 1'b0);
        n = 0;
        while (!(tid_we_o != 16'h0 && tid_wa_o == 5'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t8_reached_lane10", 64'(tid_wa_o), 64'(10));
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("t8_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t8_ready_low", 64'(launch_ready), 64'(0));
        @(negedge clk);
        check("t8_ready_high", 64'(launch_ready), 64'(1));
        check("t8_busy_low", 64'(busy), 64'(0));

        repeat (3) @(negedge clk);
        check("tid_queue_empty", 64'(tid_q.size()), 64'(0));
        check("init_queue_empty", 64'(init_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
